// File: rtl/ulpi_tx_scheduler.sv
// Round-robin owner of the ULPI transmit path: command byte, nxt-paced data, one-cycle stp.
// Define ULPI_TX_SCHEDULER_TIMEOUT_EN to force-terminate transfers stalled for TIMEOUT cycles.
module ulpi_tx_scheduler #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] src_cmd,
    input  logic [NREQ*8-1:0] src_data,
    input  logic [NREQ-1:0]   src_last,
    output logic [NREQ-1:0]   pop,
    output logic [NREQ-1:0]   grant,
    output logic              done,
    output logic              abort,
    input  logic              ulpi_dir,
    input  logic              ulpi_nxt,
    output logic [7:0]        ulpi_data_out,
    output logic              ulpi_stp
);

    localparam int IDXW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_DATA  = 3'd2,
        S_STP   = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t            state_r;
    logic [NREQ-1:0]   grant_r;
    logic [IDXW-1:0]   ptr_r;
    logic [IDXW-1:0]   idx_r;
    logic              dir_prev_r;
    logic [IDXW-1:0]   pick_s;
    logic [IDXW-1:0]   cand_s;
    logic [7:0]        cmd_s;
    logic [7:0]        data_s;
    logic              last_s;
    logic              bus_free_s;

`ifdef ULPI_TX_SCHEDULER_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT - 1);
    logic [7:0]        to_cnt_r;
    logic              to_flag_r;
`endif

    // Bus is ours only after two consecutive low-dir cycles (turnaround).
    assign bus_free_s = !ulpi_dir && !dir_prev_r;
    assign grant      = grant_r;

    // Round-robin pick: lowest offset from ptr_r with a pending request wins.
    always_comb begin
        pick_s = ptr_r;
        cand_s = ptr_r;
        for (int off = NREQ - 1; off >= 0; off--) begin
            cand_s = IDXW'((int'(ptr_r) + off) % NREQ);
            pick_s = req[cand_s] ? cand_s : pick_s;
        end
    end

    // Transfer sequencer, owner register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            grant_r    <= {NREQ{1'b0}};
            ptr_r      <= {IDXW{1'b0}};
            idx_r      <= {IDXW{1'b0}};
            dir_prev_r <= 1'b0;
`ifdef ULPI_TX_SCHEDULER_TIMEOUT_EN
            to_cnt_r   <= 8'd0;
            to_flag_r  <= 1'b0;
`endif
        end else begin
            dir_prev_r <= ulpi_dir;
            case (state_r)
                S_IDLE: begin
                    if (bus_free_s && (req != {NREQ{1'b0}})) begin
                        state_r <= S_CMD;
                        idx_r   <= pick_s;
                        grant_r <= {{(NREQ-1){1'b0}}, 1'b1} << pick_s;
`ifdef ULPI_TX_SCHEDULER_TIMEOUT_EN
                        to_cnt_r  <= 8'd0;
                        to_flag_r <= 1'b0;
`endif
                    end
                end
                S_CMD: begin
                    if (ulpi_dir) begin
                        state_r <= S_ABORT;
                    end else if (ulpi_nxt) begin
                        state_r <= S_DATA;
`ifdef ULPI_TX_SCHEDULER_TIMEOUT_EN
                        to_cnt_r <= 8'd0;
                    end else if (to_cnt_r == TO_LIMIT) begin
                        state_r   <= S_STP;
                        to_flag_r <= 1'b1;
                    end else begin
                        to_cnt_r <= to_cnt_r + 8'd1;
`endif
                    end
                end
                S_DATA: begin
                    if (ulpi_dir) begin
                        state_r <= S_ABORT;
                    end else if (ulpi_nxt) begin
                        state_r <= last_s ? S_STP : S_DATA;
`ifdef ULPI_TX_SCHEDULER_TIMEOUT_EN
                        to_cnt_r <= 8'd0;
                    end else if (to_cnt_r == TO_LIMIT) begin
                        state_r   <= S_STP;
                        to_flag_r <= 1'b1;
                    end else begin
                        to_cnt_r <= to_cnt_r + 8'd1;
`endif
                    end
                end
                S_STP: begin
                    state_r <= S_IDLE;
                    grant_r <= {NREQ{1'b0}};
                    ptr_r   <= (int'(idx_r) == NREQ - 1) ? {IDXW{1'b0}} : idx_r + IDXW'(1);
                end
                S_ABORT: begin
                    // Pointer stays put so the aborted requester is retried first.
                    state_r <= S_IDLE;
                    grant_r <= {NREQ{1'b0}};
                end
                default: begin
                    state_r <= S_IDLE;
                    grant_r <= {NREQ{1'b0}};
                end
            endcase
        end
    end

    // Output decode from the state and the granted requester's inputs.
    always_comb begin
        cmd_s  = src_cmd[{idx_r, 3'b000} +: 8];
        data_s = src_data[{idx_r, 3'b000} +: 8];
        last_s = src_last[idx_r];
        case (state_r)
            S_CMD:   ulpi_data_out = cmd_s;
            S_DATA:  ulpi_data_out = data_s;
            default: ulpi_data_out = 8'h00;
        endcase
        ulpi_stp = (state_r == S_STP);
        if ((state_r == S_DATA) && !ulpi_dir && ulpi_nxt) begin
            pop = grant_r;
        end else begin
            pop = {NREQ{1'b0}};
        end
`ifdef ULPI_TX_SCHEDULER_TIMEOUT_EN
        done  = (state_r == S_STP) && !to_flag_r;
        abort = (state_r == S_ABORT) || ((state_r == S_STP) && to_flag_r);
`else
        done  = (state_r == S_STP);
        abort = (state_r == S_ABORT);
`endif
    end

endmodule

// File: tb/tb_ulpi_tx_scheduler.sv
// Randomized and directed bench for ulpi_tx_scheduler against a transfer-level reference model.
module tb_ulpi_tx_scheduler;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*8-1:0] src_cmd;
    logic [NREQ*8-1:0] src_data;
    logic [NREQ-1:0]   src_last;
    logic [NREQ-1:0]   pop;
    logic [NREQ-1:0]   grant;
    logic              done;
    logic              abort;
    logic              ulpi_dir;
    logic              ulpi_nxt;
    logic [7:0]        ulpi_data_out;
    logic              ulpi_stp;

    ulpi_tx_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .src_cmd(src_cmd), .src_data(src_data),
        .src_last(src_last), .pop(pop), .grant(grant), .done(done), .abort(abort),
        .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt), .ulpi_data_out(ulpi_data_out),
        .ulpi_stp(ulpi_stp)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Requester side: each requester holds one transfer (command + bytes).
    logic [7:0]      r_cmd [NREQ];
    logic [7:0]      r_byte [NREQ][8];
    int              r_len [NREQ];
    int              r_pos [NREQ];
    logic [NREQ-1:0] r_req;
    int              mode;   // 0 directed, 1 back-to-back one-byte, 2 random

    // Reference model: owner (-1 idle), command accepted, ending kind
    // (0 none, 1 normal stp, 2 dir abort, 3 timeout stp), rr pointer.
    int  m_owner, m_end, m_rr, m_stall;
    bit  m_cmd_ok, m_last_dir;

    int              cnt_pop0, cnt_done, cnt_abort, cnt_stp, n_done;
    logic [NREQ-1:0] done_log [8];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic new_xfer(input int i, input int len);
        r_cmd[i] = 8'($urandom);
        r_len[i] = len;
        r_pos[i] = 0;
        for (int b = 0; b < 8; b++) r_byte[i][b] = 8'($urandom);
    endtask

    task automatic drive_src();
        for (int i = 0; i < NREQ; i++) begin
            src_cmd[i*8 +: 8]  = r_cmd[i];
            src_data[i*8 +: 8] = r_byte[i][r_pos[i]];
            src_last[i]        = (r_pos[i] == r_len[i] - 1);
        end
        req = r_req;
    endtask

    task automatic finish_req(input int i);
        if (mode == 1) new_xfer(i, 1);
        else r_req[i] = 1'b0;
    endtask

    task automatic clr_cnt();
        cnt_pop0 = 0; cnt_done = 0; cnt_abort = 0; cnt_stp = 0; n_done = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_data", ulpi_data_out, 8'h00);
        chk("rst_stp", ulpi_stp, 1'b0);
        chk("rst_pop", pop, '0);
        chk("rst_grant", grant, '0);
        chk("rst_done", done, 1'b0);
        chk("rst_abort", abort, 1'b0);
        ulpi_dir = 1'b0;
        ulpi_nxt = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_owner = -1; m_end = 0; m_rr = 0; m_stall = 0; m_cmd_ok = 0; m_last_dir = 0;
        r_req = '0;
        mode = 0;
        for (int i = 0; i < NREQ; i++) r_pos[i] = 0;
        clr_cnt();
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic cycle(input logic d, input logic n);
        logic [7:0]      e_data;
        logic            e_stp, e_done, e_abort;
        logic [NREQ-1:0] e_pop, e_grant;
        if (mode == 2) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!r_req[i] && $urandom_range(0, 3) == 0) begin
                    new_xfer(i, int'($urandom_range(1, 5)));
                    r_req[i] = 1'b1;
                end
            end
        end
        ulpi_dir = d;
        ulpi_nxt = n;
        drive_src();
        #1;
        e_data = 8'h00; e_stp = 1'b0; e_done = 1'b0; e_abort = 1'b0;
        e_pop = '0; e_grant = '0;
        if (m_owner >= 0) e_grant = oh(m_owner);
        case (m_end)
            1: begin e_stp = 1'b1; e_done = 1'b1; end
            2: e_abort = 1'b1;
            3: begin e_stp = 1'b1; e_abort = 1'b1; end
            default: begin
                if (m_owner >= 0) begin
                    if (!m_cmd_ok) begin
                        e_data = r_cmd[m_owner];
                    end else begin
                        e_data = r_byte[m_owner][r_pos[m_owner]];
                        if (n && !d) e_pop = oh(m_owner);
                    end
                end
            end
        endcase
        chk("data", ulpi_data_out, e_data);
        chk("stp", ulpi_stp, e_stp);
        chk("pop", pop, e_pop);
        chk("grant", grant, e_grant);
        chk("done", done, e_done);
        chk("abort", abort, e_abort);
        cnt_pop0  += int'(pop[0]);
        cnt_done  += int'(done);
        cnt_abort += int'(abort);
        cnt_stp   += int'(ulpi_stp);
        if (done === 1'b1 && n_done < 8) begin
            done_log[n_done] = grant;
            n_done++;
        end
        if (m_end != 0) begin
            if (m_end != 2) m_rr = (m_owner + 1) % NREQ;
            if (m_end == 1) finish_req(m_owner);
            else r_pos[m_owner] = 0;
            m_owner = -1;
            m_end = 0;
        end else if (m_owner < 0) begin
            if (!d && !m_last_dir && r_req != '0) begin
                for (int o = 0; o < NREQ; o++) begin
                    if (m_owner < 0 && r_req[(m_rr + o) % NREQ]) m_owner = (m_rr + o) % NREQ;
                end
                m_cmd_ok = 0;
                m_stall = 0;
            end
        end else if (d) begin
            m_end = 2;
        end else if (n) begin
            m_stall = 0;
            if (!m_cmd_ok) begin
                m_cmd_ok = 1;
            end else begin
                if (r_pos[m_owner] == r_len[m_owner] - 1) m_end = 1;
                r_pos[m_owner]++;
            end
        end else begin
`ifdef ULPI_TX_SCHEDULER_TIMEOUT_EN
            if (m_stall == TIMEOUT - 1) m_end = 3;
            else m_stall++;
`endif
        end
        m_last_dir = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int burst;
        rst = 1'b1;
        ulpi_dir = 1'b0;
        ulpi_nxt = 1'b0;
        r_req = '0;
        mode = 0;
        for (int i = 0; i < NREQ; i++) new_xfer(i, 1);
        drive_src();
        do_reset();

        // Single three-byte transfer with nxt held high.
        r_cmd[0] = 8'h40;
        r_byte[0][0] = 8'h11; r_byte[0][1] = 8'h22; r_byte[0][2] = 8'h33;
        r_len[0] = 3; r_pos[0] = 0;
        r_req = 2'b01;
        repeat (8) cycle(1'b0, 1'b1);
        chk("t1_pop0", cnt_pop0, 3);
        chk("t1_done", cnt_done, 1);
        chk("t1_stp", cnt_stp, 1);
        chk("t1_grant_end", grant, 2'b00);

        // Both requesters held: grants alternate.
        do_reset();
        mode = 1;
        new_xfer(0, 1); new_xfer(1, 1);
        r_req = 2'b11;
        repeat (14) cycle(1'b0, 1'b1);
        chk("t2_ndone", n_done >= 3, 1'b1);
        chk("t2_g0", done_log[0], 2'b01);
        chk("t2_g1", done_log[1], 2'b10);
        chk("t2_g2", done_log[2], 2'b01);

        // dir rises with nxt during the second data byte.
        do_reset();
        new_xfer(0, 3); new_xfer(1, 3);
        r_req = 2'b11;
        k = 0;
        while (k < 20 && !(m_owner == 0 && m_cmd_ok && r_pos[0] == 1)) begin
            cycle(1'b0, 1'b1);
            k++;
        end
        chk("t3_reach", k < 20, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        chk("t3_hold", grant, 2'b00);
        cycle(1'b0, 1'b0);
        chk("t3_regrant", grant, 2'b01);
        chk("t3_aborts", cnt_abort, 1);
        chk("t3_stp", cnt_stp, 0);
        chk("t3_pop0", cnt_pop0, 1);

        // Single low-dir cycle between PHY bursts.
        do_reset();
        new_xfer(0, 2);
        r_req = 2'b01;
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        chk("t4_single_low", grant, 2'b00);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        chk("t4_first_low", grant, 2'b00);
        cycle(1'b0, 1'b0);
        chk("t4_second_low", grant, 2'b01);

        // nxt held low in CMD for 300 cycles.
        do_reset();
        new_xfer(0, 1);
        r_cmd[0] = 8'h5A;
        r_req = 2'b01;
        cycle(1'b0, 1'b0);
        clr_cnt();
        repeat (300) cycle(1'b0, 1'b0);
`ifdef ULPI_TX_SCHEDULER_TIMEOUT_EN
        chk("t5_stp", cnt_stp, 1);
        chk("t5_abort", cnt_abort, 1);
        chk("t5_done", cnt_done, 0);
`else
        chk("t5_stp", cnt_stp, 0);
        chk("t5_abort", cnt_abort, 0);
        chk("t5_grant", grant, 2'b01);
        chk("t5_cmd", ulpi_data_out, 8'h5A);
`endif
        repeat (6) cycle(1'b0, 1'b1);

        // Reset mid-DATA after the pointer has moved to requester 1.
        do_reset();
        new_xfer(0, 1);
        r_req = 2'b01;
        repeat (6) cycle(1'b0, 1'b1);
        new_xfer(1, 4);
        r_byte[1][1] = 8'hA5;
        r_req = 2'b10;
        repeat (3) cycle(1'b0, 1'b1);
        ulpi_nxt = 1'b1;
        drive_src();
        #1;
        chk("t6_pre", {pop, ulpi_data_out}, {2'b10, 8'hA5});
        do_reset();
        new_xfer(0, 2); new_xfer(1, 2);
        r_req = 2'b11;
        cycle(1'b0, 1'b1);
        chk("t6_ptr0", grant, 2'b01);

        // Randomized traffic with PHY receive bursts.
        do_reset();
        mode = 2;
        burst = 0;
        repeat (2000) begin
            logic d;
            if (burst > 0) begin
                d = 1'b1;
                burst--;
            end else if ($urandom_range(0, 29) == 0) begin
                d = 1'b1;
                burst = int'($urandom_range(0, 3));
            end else begin
                d = 1'b0;
            end
            cycle(d, $urandom_range(0, 9) < 7);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
